multi_ch_clk_divider: RTL and testbench
=======================================

// Module: multi_ch_clk_divider
// PURPOSE
//  Parametrised N-channel square-wave divider. Successor to the fixed 500Hz/4Hz/1Hz divider.
//  Per-channel terminal counts are programmable at runtime, with glitch-free reload.
//  Also provides per-channel enables and a global phase-restart.
//  Sits at the clock tree root; feeds display scan, blink and timekeeping logic.
// PARAMETERS
//  NUM_CH   3                              number of output channels (1..16)
//  CNT_W    25                             counter/terminal-count width per channel
//  INIT_TC  {25'd24999999,25'd6249999,25'd49999}  packed reset TCs, ch0 in LSBs (half-period-1)
//  CH_W     $clog2(NUM_CH) (min 1)         width of cfg_ch
// PORTS
//  clk_in_50M  in   1             system clock, 50 MHz
//  rst_n       in   1             synchronous reset, active low
//  ch_en       in   NUM_CH        per-channel run enable
//  restart     in   1             global phase-align pulse
//  cfg_valid   in   1             config write request
//  cfg_ready   out  1             config write can be accepted
//  cfg_ch      in   CH_W          target channel
//  cfg_tc      in   CNT_W         new terminal count (half-period-1)
//  cfg_err     out  1             1-cycle pulse: accepted write had cfg_ch>=NUM_CH
//  clk_out     out  NUM_CH        divided square waves
//  tick        out  NUM_CH        1-cycle strobe per toggle (DIV_TICK_EN only)
// BEHAVIOUR
//  - Reset: sampled on rising clk_in_50M only.
//    Values: cnt=0, tc=INIT_TC, shadow=INIT_TC, pend=0, clk_out=0, tick=0, cfg_err=0, cfg_ready=1.
//  - Per channel, each cycle with ch_en[i]=1:
//    - if cnt==tc: cnt<=0, clk_out[i] toggles, tick[i]=1 for that cycle.
//    - if pend=1 at that edge: tc<=shadow, pend<=0.
//    - else: cnt<=cnt+1.
//  - Output period = 2*(tc+1) cycles, 50% duty.
//    tc=0 gives clk/2 (toggle every cycle). tc=2^CNT_W-1 is legal; cnt never wraps past tc.
//  - ch_en[i]=0: cnt, clk_out[i], tc frozen; tick[i]=0; pending reload stays pending.
//  - Config handshake: write accepted on clk edge when cfg_valid & cfg_ready.
//    - Accept writes shadow[cfg_ch]<=cfg_tc and sets pend.
//    - Takes effect at that channel's next terminal count; the current half-period completes unchanged.
//    - cfg_ready = ~pend[cfg_ch] (combinational on cfg_ch); cfg_ready=1 when cfg_ch>=NUM_CH.
//    - Out-of-range cfg_ch: write accepted, dropped, cfg_err=1 next cycle.
//    - Second write to the same channel is stalled until the reload lands.
//  - restart=1 (priority over terminal count and cfg):
//    - all channels: cnt<=0, clk_out<=0, tick<=0.
//    - pending shadows applied immediately (tc<=shadow, pend<=0).
//    - Applies regardless of ch_en. cfg_ready=0 during restart; no write accepted that cycle.
//  - rst_n low mid-operation: full return to reset state next edge; in-flight config discarded.
//  - All outputs registered; no combinational path from inputs to clk_out/tick.
//    cfg_ready is the exception (depends on cfg_ch).
// CONFIGURATION
//  DIV_TICK_EN defined:
//    - tick port present.
//    - tick[i] pulses for exactly one cycle on the edge where clk_out[i] toggles
//      (registered, coincident with the clk_out change).
//  DIV_TICK_EN undefined:
//    - tick port and its logic absent.
//    - all other behaviour identical.
// TESTING (bench with NUM_CH=3, CNT_W=8, INIT_TC={8'd9,8'd3,8'd1})
//  - Release rst_n, ch_en=3'b111 -> clk_out[0] period 4, [1] 8, [2] 20 cycles; first toggles at cycles 2/4/10.
//  - Write ch1 tc=0 at cnt=1 of tc=3 -> current half-period stays 4 cycles, then ch1 toggles every cycle.
//    cfg_ready low for ch1 until the reload lands.
//  - restart on the same cycle as ch2 terminal count -> no toggle, no tick.
//    All clk_out=0, cnt=0; pending reload applied.
//  - ch_en[0]=0 for 7 cycles mid-period -> clk_out[0] held; the phase resumes shifted by 7 cycles.
//  - cfg_ch=3 write -> accepted, cfg_err 1 cycle, no channel changes.
//    rst_n low mid-run -> all outputs 0 and TCs back to INIT_TC.
//  - Build without DIV_TICK_EN -> clk_out waveforms bit-identical to the DIV_TICK_EN build.

Source files
------------

// File: rtl/multi_ch_clk_divider_if.sv
// Configuration write channel of multi_ch_clk_divider: valid/ready handshake
// selecting a channel and carrying its new terminal count, plus the error strobe.
`timescale 1ns/1ps

interface multi_ch_clk_divider_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 25
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_tc;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_tc,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_tc,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/multi_ch_clk_divider.sv
// N-channel 50% duty square-wave divider with runtime-programmable terminal counts,
// glitch-free shadow reload, per-channel enables and global restart. DIV_TICK_EN adds tick.
`timescale 1ns/1ps

module multi_ch_clk_divider #(
  parameter int                      NUM_CH  = 3,
  parameter int                      CNT_W   = 25,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_TC = {25'd24999999, 25'd6249999, 25'd49999},
  parameter int                      CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_in_50M,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                restart,
  multi_ch_clk_divider_if.slave cfg,
  output logic [NUM_CH-1:0]   clk_out
`ifdef DIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]   tick
`endif
);

  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  tc     [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr_hit;
  logic              sel_pend;
  logic              in_range;
  logic              accept;

  // Decode cfg_ch without indexing past NUM_CH; out-of-range selects nothing.
  always_comb begin
    wr_hit   = '0;
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        wr_hit[i] = 1'b1;
        sel_pend  = pend[i];
      end
    end
  end

  assign in_range      = |wr_hit;
  assign cfg.cfg_ready = ~restart & ~sel_pend;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  always_ff @(posedge clk_in_50M) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        tc[i]     <= INIT_TC[i*CNT_W +: CNT_W];
        shadow[i] <= INIT_TC[i*CNT_W +: CNT_W];
      end
      pend        <= '0;
      clk_out     <= '0;
      cfg.cfg_err <= 1'b0;
`ifdef DIV_TICK_EN
      tick        <= '0;
`endif
    end else begin
      cfg.cfg_err <= accept & ~in_range;
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef DIV_TICK_EN
        tick[i] <= 1'b0;
`endif
        if (restart) begin
          // Restart overrides everything, even disabled channels, and flushes pending reloads.
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          if (pend[i]) begin
            tc[i]   <= shadow[i];
            pend[i] <= 1'b0;
          end
        end else begin
          if (ch_en[i]) begin
            if (cnt[i] == tc[i]) begin
              cnt[i]     <= '0;
              clk_out[i] <= ~clk_out[i];
`ifdef DIV_TICK_EN
              tick[i]    <= 1'b1;
`endif
              if (pend[i]) begin
                tc[i]   <= shadow[i];
                pend[i] <= 1'b0;
              end
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          // An accept needs pend clear, so it never collides with the reload above.
          if (accept && wr_hit[i]) begin
            shadow[i] <= cfg.cfg_tc;
            pend[i]   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_ch_clk_divider.sv
// Directed + randomised scoreboard bench for multi_ch_clk_divider (NUM_CH=3, CNT_W=8).
// Tick checks are compiled in only when DIV_TICK_EN is defined.
`timescale 1ns/1ps

module tb_multi_ch_clk_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam logic [NUM_CH*CNT_W-1:0] INIT_TC = {8'd9, 8'd3, 8'd1};

  logic              clk_in_50M = 1'b0;
  logic              rst_n      = 1'b0;
  logic              restart    = 1'b0;
  logic [NUM_CH-1:0] ch_en      = '0;
  logic [NUM_CH-1:0] clk_out;
`ifdef DIV_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif

  multi_ch_clk_divider_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

  multi_ch_clk_divider #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .INIT_TC(INIT_TC),
    .CH_W   (CH_W)
  ) dut (
    .clk_in_50M(clk_in_50M),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .restart   (restart),
    .cfg       (cfg.slave),
    .clk_out   (clk_out)
`ifdef DIV_TICK_EN
    ,
    .tick      (tick)
`endif
  );

  always #5 clk_in_50M = ~clk_in_50M;

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tk;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  logic [CNT_W-1:0]  m_tc  [NUM_CH];
  logic [CNT_W-1:0]  m_sh  [NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_clk, m_tick;
  logic              m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, want);
    end
  endtask

  function automatic logic modelReady();
    if (restart) return 1'b0;
    if (cfg.cfg_ch >= 2'd3) return 1'b1;
    return ~m_pend[cfg.cfg_ch];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = '0;
      m_tc[i]  = INIT_TC[i*CNT_W +: CNT_W];
      m_sh[i]  = INIT_TC[i*CNT_W +: CNT_W];
    end
    m_pend = '0;
    m_clk  = '0;
    m_tick = '0;
    m_err  = 1'b0;
  endtask

  // Advance the reference model by one edge using the inputs now on the pins.
  task automatic modelStep();
    logic acc;
    acc = cfg.cfg_valid && modelReady();
    if (!rst_n) begin
      modelReset();
    end else begin
      m_err = acc && (cfg.cfg_ch == 2'd3);
      for (int i = 0; i < NUM_CH; i++) begin
        m_tick[i] = 1'b0;
        if (restart) begin
          m_cnt[i] = '0;
          m_clk[i] = 1'b0;
          if (m_pend[i]) begin
            m_tc[i]   = m_sh[i];
            m_pend[i] = 1'b0;
          end
        end else if (ch_en[i]) begin
          if (m_cnt[i] == m_tc[i]) begin
            m_cnt[i]  = '0;
            m_clk[i]  = ~m_clk[i];
            m_tick[i] = 1'b1;
            if (m_pend[i]) begin
              m_tc[i]   = m_sh[i];
              m_pend[i] = 1'b0;
            end
          end else begin
            m_cnt[i] = m_cnt[i] + 8'd1;
          end
        end
        if (acc && cfg.cfg_ch == CH_W'(i)) begin
          m_sh[i]   = cfg.cfg_tc;
          m_pend[i] = 1'b1;
        end
      end
    end
    sb.push_back('{m_clk, m_tick, m_err});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty at cycle %0d: observed 0 entries expected 1", cyc);
    end else begin
      e = sb.pop_front();
      check("sb_clk_out", 32'(clk_out), 32'(e.clk));
      check("sb_cfg_err", 32'(cfg.cfg_err), 32'(e.err));
`ifdef DIV_TICK_EN
      check("sb_tick", 32'(tick), 32'(e.tk));
`endif
    end
  endtask

  // One clock: check combinational ready, predict, clock, compare.
  task automatic applyStimulus();
    #1;
    check("sb_cfg_ready", 32'(cfg.cfg_ready), 32'(modelReady()));
    modelStep();
    @(posedge clk_in_50M);
    #1;
    cyc++;
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_tc    = '0;
    @(posedge clk_in_50M);
    #1;
    modelReset();

    applyStimulus();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_cfg_err", 32'(cfg.cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg.cfg_ready), 32'd1);

    $display("[TB] release reset, all channels enabled");
    rst_n = 1'b1;
    ch_en = 3'b111;
    cyc   = 0;
    repeat (2) applyStimulus();
    check("first_toggle_c2", 32'(clk_out), 32'b001);
    repeat (2) applyStimulus();
    check("first_toggle_c4", 32'(clk_out), 32'b010);
    repeat (6) applyStimulus();
    check("first_toggle_c10", 32'(clk_out), 32'b101);
`ifdef DIV_TICK_EN
    check("tick_c10", 32'(tick), 32'b101);
`endif
    repeat (3) applyStimulus();

    $display("[TB] reload ch1 to tc=0 mid half-period");
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd1;
    cfg.cfg_tc    = 8'd0;
    #1;
    check("ready_ch1_idle", 32'(cfg.cfg_ready), 32'd1);
    applyStimulus();
    cfg.cfg_tc = 8'd5;
    #1;
    check("ready_ch1_pending", 32'(cfg.cfg_ready), 32'd0);
    applyStimulus();
    check("ch1_half_period_kept", 32'(clk_out[1]), 32'd1);
    cfg.cfg_valid = 1'b0;
    applyStimulus();
    check("ch1_toggle_c16", 32'(clk_out[1]), 32'd0);
    #1;
    check("ready_ch1_landed", 32'(cfg.cfg_ready), 32'd1);
    applyStimulus();
    check("ch1_fast_c17", 32'(clk_out[1]), 32'd1);

    $display("[TB] pending ch2 write then restart on its terminal count");
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd2;
    cfg.cfg_tc    = 8'd4;
    applyStimulus();
    cfg.cfg_valid = 1'b0;
    applyStimulus();
    restart = 1'b1;
    #1;
    check("ready_during_restart", 32'(cfg.cfg_ready), 32'd0);
    applyStimulus();
    restart = 1'b0;
    check("restart_clk_out", 32'(clk_out), 32'd0);
`ifdef DIV_TICK_EN
    check("restart_tick", 32'(tick), 32'd0);
`endif
    repeat (5) applyStimulus();
    check("after_restart_c25", 32'(clk_out), 32'b110);

    $display("[TB] hold ch0 for 7 cycles");
    ch_en = 3'b110;
    repeat (7) applyStimulus();
    check("ch0_held", 32'(clk_out[0]), 32'd0);
    ch_en = 3'b111;
    applyStimulus();
    check("ch0_resumed", 32'(clk_out[0]), 32'd1);
    applyStimulus();

    $display("[TB] out-of-range channel write");
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd3;
    cfg.cfg_tc    = 8'h55;
    #1;
    check("ready_out_of_range", 32'(cfg.cfg_ready), 32'd1);
    applyStimulus();
    cfg.cfg_valid = 1'b0;
    check("cfg_err_pulse", 32'(cfg.cfg_err), 32'd1);
    applyStimulus();
    check("cfg_err_clear", 32'(cfg.cfg_err), 32'd0);

    $display("[TB] reset mid-run discards pending write");
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd0;
    cfg.cfg_tc    = 8'd7;
    applyStimulus();
    cfg.cfg_valid = 1'b0;
    applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    check("midrun_rst_clk_out", 32'(clk_out), 32'd0);
    #1;
    check("midrun_rst_ready_ch0", 32'(cfg.cfg_ready), 32'd1);
    rst_n = 1'b1;
    cyc   = 0;
    repeat (2) applyStimulus();
    check("post_rst_c2", 32'(clk_out), 32'b001);
    repeat (8) applyStimulus();
    check("post_rst_c10", 32'(clk_out), 32'b101);

    $display("[TB] randomised traffic");
    repeat (300) begin
      ch_en         = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b111;
      restart       = ($urandom_range(23) == 0);
      rst_n         = ($urandom_range(99) != 0);
      cfg.cfg_valid = 1'($urandom_range(1));
      cfg.cfg_ch    = 2'($urandom_range(3));
      cfg.cfg_tc    = 8'($urandom_range(5));
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
